multiplier_thirtytwo_bit: RTL

MULTIPLIER_THIRTYTWO_BIT -- requirements
Module: multiplier_thirtytwo_bit

---
 rtl/multiplier_thirtytwo_bit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multiplier_thirtytwo_bit.sv
// ---------------------------------------------------------------------------
// multiplier_thirtytwo_bit
//   Sequential 32x32 -> 64-bit multiplier (MULT / MULTU), radix-2 shift-add.
//   Fixed latency: 33 clocks from the start-sampling edge to the edge that
//   raises done. Signed operands are reduced to magnitudes up front and the
//   product is conditionally negated in a single FIXSIGN cycle.
//
// Parameters
//   SIGNED_EN : 1 = honour is_signed, 0 = every operation is unsigned
//
// Ports
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   request a multiply (accepted only in IDLE)
//   is_signed in   1   1 = two's complement, 0 = unsigned
//   inp0      in   32  multiplicand
//   inp1      in   32  multiplier
//   busy      out  1   operation in progress
//   done      out  1   one-cycle pulse, hi/lo valid
//   hi        out  32  upper half of product
//   lo        out  32  lower half of product
// ---------------------------------------------------------------------------

// 32-bit adder used by the shift-add datapath; cout is the 65th acc bit.
module full_adder_thirtytwo_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module multiplier_thirtytwo_bit #(
    parameter int SIGNED_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] inp0,
    input  logic [31:0] inp1,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIXSIGN, DONE} state_t;

    state_t      state, next_state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;   // starts as the multiplier, fills with product LSBs
    logic        neg;

    logic        use_signed;
    logic [31:0] abs0, abs1;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [63:0] prod, prod_fix;

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
    assign use_signed = (SIGNED_EN != 0) && is_signed;
    assign abs0       = (use_signed && inp0[31]) ? (~inp0 + 32'd1) : inp0;
    assign abs1       = (use_signed && inp1[31]) ? (~inp1 + 32'd1) : inp1;

    assign add_b = acc_lo[0] ? mcand : 32'd0;

    full_adder_thirtytwo_bit u_add (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg ? (~prod + 64'd1) : prod;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == 5'd31) next_state = FIXSIGN;
            FIXSIGN: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 5'd0;
            mcand  <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            neg    <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= 5'd0;
                        mcand  <= abs0;
                        acc_hi <= 32'd0;
                        acc_lo <= abs1;
                        neg    <= use_signed & (inp0[31] ^ inp1[31]);
                    end
                end
                CALC: begin
                    // add-then-shift of the 65-bit {cout, sum, acc_lo}
                    {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[31:1]};
                    cnt              <= cnt + 5'd1;
                end
                FIXSIGN: begin
                    {acc_hi, acc_lo} <= prod_fix;
                    hi               <= prod_fix[63:32];
                    lo               <= prod_fix[31:0];
                end
                default: ;
            endcase
        end
    end

endmodule
